// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and helpers for the PWM stage
package pwm_pkg;

    localparam int PWM_PERIOD_DEFAULT = 100;
    // Half-period count of the 50 kHz step divider feeding this stage
    localparam int STEP_HALF_COUNT = 999;

    function automatic int duty_width(input int period);
        return $clog2(period + 1);
    endfunction

endpackage

// File: rtl/rise_det.sv
// rtl/rise_det.sv - 1-bit rising-edge detector, delay register resets high
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Resetting high hides an input that is already high when reset releases
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - PWM generator stepped by divider rising edges, double-buffered duty
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD_DEFAULT,
    parameter int DW     = duty_width(PERIOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_in,
    input  logic          en,
    input  logic [DW-1:0] duty,
    input  logic          duty_wr,
    output logic          duty_busy,
    output logic          period_start,
    output logic          pwm_out
);

    localparam logic [DW-1:0] LAST = DW'(PERIOD - 1);

    logic          step;
    logic          wrap;
    logic          load;
    logic          pending;
    logic [DW-1:0] cnt;
    logic [DW-1:0] shadow;
    logic [DW-1:0] duty_act;

    rise_det u_step (
        .clk  (clk),
        .rst  (rst),
        .d    (tick_in),
        .rise (step)
    );

    assign wrap = en & step & (cnt == LAST);
    // A disabled stage has no period to protect, so a pending duty applies at once
    assign load = pending & (wrap | ~en);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            shadow       <= '0;
            duty_act     <= '0;
            pending      <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            if (!en) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= wrap ? '0 : cnt + DW'(1);
            end

            if (duty_wr) begin
                shadow <= duty;
            end

            // A write in a load cycle keeps the new value pending for the next boundary
            if (duty_wr) begin
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end

            if (load) begin
                duty_act <= shadow;
            end

            period_start <= wrap;
            pwm_out      <= en & (cnt < duty_act);
        end
    end

    assign duty_busy = pending;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed self-checking bench for pwm_gen with PERIOD=4
module tb_pwm_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       en;
    logic [2:0] duty;
    logic       duty_wr;
    logic       duty_busy;
    logic       period_start;
    logic       pwm_out;

    int vectors     = 0;
    int miscompares = 0;
    int hi_cnt      = 0;
    int ps_cnt      = 0;

    pwm_gen #(.PERIOD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .en           (en),
        .duty         (duty),
        .duty_wr      (duty_wr),
        .duty_busy    (duty_busy),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_duty(input logic [2:0] v);
        duty    = v;
        duty_wr = 1'b1;
        cyc();
        duty_wr = 1'b0;
    endtask

    // One tick_in period: 4 clocks high then 4 low; first edge is the step edge
    task automatic step8(input logic wr, input logic [2:0] wval);
        tick_in = 1'b1;
        if (wr) begin
            duty    = wval;
            duty_wr = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 4) tick_in = 1'b0;
            cyc();
            if (i == 0) duty_wr = 1'b0;
            hi_cnt += int'(pwm_out);
            ps_cnt += int'(period_start);
        end
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step8(1'b0, 3'd0);
    endtask

    initial begin
        int exp_hi [3];
        logic [2:0] ext [3];
        ext[0] = 3'd0; ext[1] = 3'd4; ext[2] = 3'd7;
        exp_hi[0] = 0; exp_hi[1] = 32; exp_hi[2] = 32;

        rst = 1'b1; tick_in = 1'b1; en = 1'b1; duty = 3'd0; duty_wr = 1'b0;
        cyc(); cyc();
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_busy", int'(duty_busy), 0);
        check("rst_ps", int'(period_start), 0);
        rst = 1'b0;
        cyc();
        check("rst_no_step_cnt", int'(dut.cnt), 0);

        // Duty 2 loaded while disabled, then run
        tick_in = 1'b0; en = 1'b0;
        cyc();
        write_duty(3'd2);
        check("pre_busy_set", int'(duty_busy), 1);
        cyc();
        check("pre_busy_clr", int'(duty_busy), 0);
        en = 1'b1;
        cyc();
        check("en_pwm_valid", int'(pwm_out), 1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) begin hi_cnt = 0; ps_cnt = 0; end
            step8(1'b0, 3'd0);
            check("d2_cnt", int'(dut.cnt), i % 4);
            check("d2_pwm", int'(pwm_out), ((i % 4) < 2) ? 1 : 0);
        end
        check("d2_hi_clocks", hi_cnt, 16);
        check("d2_ps_pulses", ps_cnt, 1);

        // Extremes: 0, exactly PERIOD, above PERIOD
        for (int k = 0; k < 3; k++) begin
            write_duty(ext[k]);
            check("ext_busy_set", int'(duty_busy), 1);
            run_steps(4);
            check("ext_busy_clr", int'(duty_busy), 0);
            hi_cnt = 0; ps_cnt = 0;
            run_steps(4);
            check("ext_hi_clocks", hi_cnt, exp_hi[k]);
            check("ext_ps_pulses", ps_cnt, 1);
        end

        // Mid-period write holds the old duty until the wrap
        write_duty(3'd2);
        run_steps(4);
        step8(1'b0, 3'd0);
        write_duty(3'd3);
        check("mid_busy", int'(duty_busy), 1);
        step8(1'b0, 3'd0);
        check("mid_old_duty_pwm", int'(pwm_out), 0);
        check("mid_busy_hold", int'(duty_busy), 1);
        step8(1'b0, 3'd0);
        check("mid_old_duty_pwm3", int'(pwm_out), 0);
        step8(1'b0, 3'd0);
        check("mid_busy_clr", int'(duty_busy), 0);
        hi_cnt = 0;
        run_steps(4);
        check("mid_new_hi_clocks", hi_cnt, 24);

        // Write coincident with wrap: old shadow loads, new one stays pending
        step8(1'b0, 3'd0);
        write_duty(3'd2);
        run_steps(2);
        step8(1'b1, 3'd1);
        check("coin_busy", int'(duty_busy), 1);
        check("coin_act", int'(dut.duty_act), 2);
        hi_cnt = 0;
        run_steps(4);
        check("coin_hi_d2", hi_cnt, 16);
        check("coin_busy_clr", int'(duty_busy), 0);
        hi_cnt = 0;
        run_steps(4);
        check("coin_hi_d1", hi_cnt, 8);

        // Enable drop mid-period applies a pending duty immediately
        write_duty(3'd3);
        run_steps(2);
        check("en_cnt_before", int'(dut.cnt), 2);
        en = 1'b0;
        cyc();
        check("en_off_pwm", int'(pwm_out), 0);
        check("en_off_cnt", int'(dut.cnt), 0);
        check("en_off_busy", int'(duty_busy), 0);
        check("en_off_act", int'(dut.duty_act), 3);
        cyc(); cyc();
        en = 1'b1;
        cyc();
        check("en_on_pwm", int'(pwm_out), 1);
        check("en_on_cnt", int'(dut.cnt), 0);
        hi_cnt = 0; ps_cnt = 0;
        run_steps(4);
        check("en_on_hi_clocks", hi_cnt, 24);
        check("en_on_ps", ps_cnt, 1);

        // Reset mid-period discards everything
        run_steps(2);
        write_duty(3'd1);
        rst = 1'b1;
        cyc();
        check("mrst_cnt", int'(dut.cnt), 0);
        check("mrst_pwm", int'(pwm_out), 0);
        check("mrst_busy", int'(duty_busy), 0);
        check("mrst_act", int'(dut.duty_act), 0);
        check("mrst_shadow", int'(dut.shadow), 0);
        rst = 1'b0;
        cyc();
        check("mrst_pwm_after", int'(pwm_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

PWM generator stage fed by the 50 kHz divider output. Each rising edge of the divider square wave is one PWM step. A step counter spans a programmable number of steps per PWM period, and the output is high while the count is below the active duty value. Duty updates are double-buffered and take effect only at a period boundary, so the output never glitches mid-period.

## Interface
Parameters:
- PERIOD, default 100: steps per PWM period (≥2); at 50 kHz steps this gives a 500 Hz PWM.
- DW, default $clog2(PERIOD+1): duty width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- tick_in  in  1  50 kHz square wave from the divider (same clock domain, registered).
- en  in  1  run enable.
- duty  in  DW  requested duty, in steps.
- duty_wr  in  1  one-clock strobe that captures duty.
- duty_busy  out  1  high while a captured duty is waiting for a period boundary.
- period_start  out  1  one-clock pulse on counter wrap.
- pwm_out  out  1  registered PWM output.

## Operation
- Step detect: keep a one-register delay tick_d of tick_in. step = tick_in & ~tick_d.
- Counter cnt (DW bits):
  - When en=1 and step=1: if cnt==PERIOD-1, cnt←0 and wrap occurs; otherwise cnt←cnt+1.
  - When en=0: cnt←0, no steps counted.
- Duty registers:
  - duty_wr: shadow←duty, pending←1. A second write while pending overwrites shadow; pending stays 1.
  - On wrap with pending=1: duty_act←shadow, pending←0. This uses shadow and pending as they were before the current cycle.
  - If duty_wr coincides with the wrap, the wrap loads the old shadow. The new value stays pending for the next wrap.
  - While en=0: a pending shadow is applied on the next clock. If duty_wr also occurs in that cycle, the rule above applies.
- Compare: pwm_out ← en & (cnt < duty_act), evaluated on registered values.
  - duty_act=0 gives constant low.
  - duty_act≥PERIOD gives constant high (clamp, no wrap-around of the compare).
- duty_busy = pending.
- period_start is registered and high for one clock, in the cycle after a wrap.
- Reset values: cnt=0, shadow=0, duty_act=0, pending=0, pwm_out=0, period_start=0, tick_d=1. Setting tick_d=1 suppresses a spurious step if tick_in is high when reset releases.
- Reset mid-period aborts the period and discards any pending duty.

## Timing
- Step latency: the cycle in which tick_in is first seen high produces step, and cnt updates at the end of that cycle.
- pwm_out lags cnt by one clock.
- So a step's effect on pwm_out appears 2 clocks after tick_in rises.
- A duty change appears on pwm_out 1 clock after the wrap that loads it, which is also the first cycle of the new period.
- en falling edge: pwm_out goes low on the next clock edge, and cnt=0 from then on.
- en rising edge: counting starts at cnt=0. The first period runs with duty_act, and pwm_out is valid 1 clock after en.
- Step throughput: one step per tick_in period (2000 clocks from the divider). Any step spacing of 2 or more clocks is supported.

## Structure
- Shared package pwm_pkg holds:
  - PWM_PERIOD_DEFAULT = 100
  - function duty_width(period)
  - the step-rate constant shared with the divider (half-period count 999)
- One sub-module, rise_det: a 1-bit rising-edge detector with reset value 1 on its delay register. It is reused by other stages.
- Everything else stays flat in pwm_gen.

## Test plan
Conditions: PERIOD=4, tick_in as a square wave of period 8 clocks, en=1 unless stated.

- Reset: hold rst with tick_in=1 and release → no step in the first cycle. cnt=0, pwm_out=0, duty_busy=0.
- duty=2 written before start, then run → pwm_out high for 2 steps (16 clocks) and low for 2 steps (16 clocks), repeating. period_start pulses every 32 clocks.
- Duty extremes: duty=0 → pwm_out constant 0. duty=4 and duty=7 → pwm_out constant 1 after load, with no wrap artefacts.
- Mid-period write: duty_wr(3) at cnt=1 → duty_busy=1 until the wrap. The old duty holds for the rest of the period, and the next period is high for 3 steps.
- Write coincident with wrap: duty_wr(1) in the wrap cycle → the old shadow is loaded, duty_busy stays 1, and duty 1 takes effect at the following wrap.
- Enable and reset mid-period:
  - en←0 at cnt=2 → pwm_out=0 next clock, cnt=0, and a pending duty is applied on the next clock.
  - en←1 → a fresh period starts.
  - rst mid-period → all registers return to their reset values.
